// File: rtl/sinfonia_pkg.sv
// Shared types and sizes for the note sequencer.
// Holds the FSM state encoding and note/address widths.
package sinfonia_pkg;

  localparam int NOTE_W = 7;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 32;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENDERECA = 3'd1,
    LE       = 3'd2,
    TOCA     = 3'd3,
    PAUSA    = 3'd4,
    PROXIMO  = 3'd5,
    FIM      = 3'd6
  } estado_t;

  function automatic logic nota_valida(
    input logic [NOTE_W-1:0] n
  );
    return $onehot(n);
  endfunction

  // Bit i of a one-hot note maps to code i+1; invalid notes map to silence.
  function automatic logic [2:0] nota_codigo(
    input logic [NOTE_W-1:0] n
  );
    logic [2:0] c;
    c = '0;
    if (nota_valida(n)) begin
      for (int i = 0; i < NOTE_W; i++) begin
        if (n[i]) c = 3'(i + 1);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sequenciador_notas_if.sv
// Control, melody-memory and output bundle of the sequencer.
// The sequencer is the slave; the environment is the master.
interface sequenciador_notas_if;
  import sinfonia_pkg::*;

  logic              iniciar;
  logic              abortar;
  logic [ADDR_W-1:0] limite;
  logic [ADDR_W-1:0] mem_endereco;
  logic [NOTE_W-1:0] mem_dado;
  logic [2:0]        arduino_out;
  logic [NOTE_W-1:0] leds;
  logic              tocando;
  logic              pronto;
  logic              erro_nota;
  logic [2:0]        db_estado;

  modport master (
    output iniciar, abortar, limite, mem_dado,
    input  mem_endereco, arduino_out, leds,
    input  tocando, pronto, erro_nota, db_estado
  );

  modport slave (
    input  iniciar, abortar, limite, mem_dado,
    output mem_endereco, arduino_out, leds,
    output tocando, pronto, erro_nota, db_estado
  );

endinterface

// File: rtl/temporizador_nota.sv
// Loadable down-counter timing the note and gap phases.
// fim is high while the count sits at zero.
module temporizador_nota
  import sinfonia_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             carregar,
  input  logic             habilita,
  input  logic [CNT_W-1:0] valor,
  output logic             fim
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carregar) begin
      cnt_d = valor;
    end else if (habilita && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fim = (cnt_q == '0);

endmodule

// File: rtl/sequenciador_notas.sv
// Plays notes 0..limite from a melody memory, each note
// followed by a silent gap, then pulses pronto.
module sequenciador_notas
  import sinfonia_pkg::*;
#(
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 5000000
) (
  input  logic clock,
  input  logic reset,
  sequenciador_notas_if.slave bus
);

  localparam logic [CNT_W-1:0] NOTE_LOAD =
    CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD =
    CNT_W'(GAP_CYCLES - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic [NOTE_W-1:0] nota_q, nota_d;
  logic              erro_q, erro_d;

  logic             carregar;
  logic             habilita;
  logic [CNT_W-1:0] valor;
  logic             fim_tempo;

  temporizador_nota u_tempo (
    .clock    (clock),
    .reset    (reset),
    .carregar (carregar),
    .habilita (habilita),
    .valor    (valor),
    .fim      (fim_tempo)
  );

  always_comb begin
    estado_d = estado_q;
    end_d    = end_q;
    lim_d    = lim_q;
    nota_d   = nota_q;
    erro_d   = erro_q;
    carregar = 1'b0;
    habilita = 1'b0;
    valor    = '0;
    // Abort wins over everything once a sequence is running.
    if (estado_q != OCIOSO && bus.abortar) begin
      estado_d = OCIOSO;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          if (bus.iniciar && !bus.abortar) begin
            estado_d = ENDERECA;
            lim_d    = bus.limite;
            end_d    = '0;
            erro_d   = 1'b0;
          end
        end
        ENDERECA: estado_d = LE;
        LE: begin
          estado_d = TOCA;
          nota_d   = bus.mem_dado;
          carregar = 1'b1;
          valor    = NOTE_LOAD;
          if (!nota_valida(bus.mem_dado)) erro_d = 1'b1;
        end
        TOCA: begin
          habilita = 1'b1;
          if (fim_tempo) begin
            estado_d = PAUSA;
            carregar = 1'b1;
            valor    = GAP_LOAD;
          end
        end
        PAUSA: begin
          habilita = 1'b1;
          if (fim_tempo) estado_d = PROXIMO;
        end
        PROXIMO: begin
          if (end_q == lim_q) begin
            estado_d = FIM;
          end else begin
            estado_d = ENDERECA;
            end_d    = end_q + 1'b1;
          end
        end
        FIM:     estado_d = OCIOSO;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      end_q    <= '0;
      lim_q    <= '0;
      nota_q   <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      end_q    <= end_d;
      lim_q    <= lim_d;
      nota_q   <= nota_d;
      erro_q   <= erro_d;
    end
  end

  logic soando;
  assign soando = (estado_q == TOCA) && nota_valida(nota_q);

  assign bus.mem_endereco = end_q;
  assign bus.arduino_out  = soando ? nota_codigo(nota_q) : 3'd0;
  assign bus.leds         = soando ? nota_q : '0;
  assign bus.tocando      = (estado_q != OCIOSO);
  assign bus.pronto       = (estado_q == FIM);
  assign bus.erro_nota    = erro_q;
  assign bus.db_estado    = estado_q;

endmodule

// File: doc/sequenciador_notas.md
SEQUENCIADOR_NOTAS -- requirements
Module: sequenciador_notas

Interface
REQ-001 Parameter NOTE_CYCLES, default 25000000, meaning clock cycles each note is held (minimum 1).
REQ-002 Parameter GAP_CYCLES, default 5000000, meaning silent cycles after each note (minimum 1).
REQ-003 Port clock  input  1  the single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port iniciar  input  1  one-cycle start pulse.
REQ-006 Port abortar  input  1  level abort request.
REQ-007 Port limite  input  4  address of the last note to play.
REQ-008 Port mem_endereco  output  4  read address to the melody memory.
REQ-009 Port mem_dado  input  7  one-hot note from the synchronous memory, valid one cycle after the address.
REQ-010 Port arduino_out  output  3  note code to the Arduino; 0 means silence.
REQ-011 Port leds  output  7  one-hot note mirror.
REQ-012 Port tocando  output  1  high in every state except OCIOSO.
REQ-013 Port pronto  output  1  one-cycle pulse when the sequence completes.
REQ-014 Port erro_nota  output  1  sticky flag for invalid memory data.
REQ-015 Port db_estado  output  3  current state code.

Function
REQ-016 The FSM SHALL have seven states with these codes: OCIOSO=0, ENDERECA=1, LE=2, TOCA=3, PAUSA=4, PROXIMO=5, FIM=6.
REQ-017 OCIOSO behaviour:
- iniciar high moves to ENDERECA.
- On that edge: limite is latched, the address is cleared to 0, and erro_nota is cleared.
REQ-018 ENDERECA SHALL last 1 cycle and go to LE; LE SHALL last 1 cycle, latch mem_dado into the note register, and go to TOCA.
REQ-019 TOCA SHALL last exactly NOTE_CYCLES cycles.
- arduino_out = index of the set bit + 1 (bit0→1 … bit6→7).
- leds = latched note.
REQ-020 Invalid latched note (zero or more than one bit set):
- TOCA still lasts NOTE_CYCLES cycles.
- arduino_out and leds are 0.
- erro_nota is set.
REQ-021 PAUSA SHALL last exactly GAP_CYCLES cycles with arduino_out=0 and leds=0, then go to PROXIMO.
REQ-022 PROXIMO SHALL last 1 cycle.
- Address equal to the latched limite → FIM.
- Otherwise the address increments → ENDERECA.
REQ-023 FIM SHALL assert pronto for exactly 1 cycle and return to OCIOSO.
REQ-024 iniciar SHALL be ignored in every state other than OCIOSO.
REQ-025 abortar high in any state other than OCIOSO SHALL force OCIOSO on the next edge.
- arduino_out and leds are cleared.
- pronto is not asserted.
- The address is held.
REQ-026 abortar and iniciar both high in OCIOSO SHALL leave the FSM in OCIOSO.
REQ-027 limite=0 SHALL play exactly one note; a change on limite during playback SHALL have no effect.
REQ-028 Address arithmetic SHALL be 4-bit; limite=15 plays 16 notes with no wrap-around before FIM.
REQ-029 Total latency from the iniciar edge to the pronto pulse SHALL be (limite+1)·(3+NOTE_CYCLES+GAP_CYCLES)+1 cycles.

Reset
REQ-030 reset low SHALL asynchronously force:
- state OCIOSO, address 0, note register 0;
- arduino_out=0, leds=0, tocando=0, pronto=0, erro_nota=0, db_estado=0.
REQ-031 Reset mid-sequence SHALL abandon the sequence without a pronto pulse; operation resumes on the first edge after reset is released.

Structure
REQ-032 The state encoding, NOTE_W=7 and ADDR_W=4 SHALL reside in the shared package sinfonia_pkg.
REQ-033 TOCA and PAUSA timing SHALL use one sub-module, temporizador_nota: a down-counter with load value, enable and a done flag, reloaded on entry to each timed state.

Verification (NOTE_CYCLES=4, GAP_CYCLES=2; memory 0:0000001, 1:0000100, 2:1000000)
REQ-034 Normal play: limite=2, pulse iniciar.
- arduino_out shows 1, 3, 7, each for 4 cycles with 2 silent cycles between.
- pronto pulses exactly 28 cycles after the iniciar edge.
REQ-035 Single note: limite=0.
- One note with arduino_out=1 for 4 cycles.
- pronto pulses 10 cycles after iniciar.
REQ-036 Abort: abortar for 1 cycle during the second TOCA.
- Next cycle: OCIOSO, arduino_out=0, tocando=0.
- No pronto pulse.
REQ-037 Invalid data: address 1 holds 0000101, limite=1.
- Second TOCA has arduino_out=0.
- erro_nota=1 until the next iniciar.
- pronto still pulses.
REQ-038 Busy and reset:
- iniciar during PAUSA is ignored.
- reset low during TOCA immediately gives all outputs 0 and state 0.
REQ-039 limite=15 with all memory locations 0000010: 16 notes with arduino_out=2 play, then pronto.
